// File: rtl/motor_uart_rx.sv
// 8N1 UART receiver that decodes the drive_motor byte stream into two signed
// motor commands, with a watchdog that stops both motors when the link goes quiet.
module motor_uart_rx #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 9600,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       uart_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       framing_error,
  output logic [7:0] motor1_cmd,
  output logic [7:0] motor2_cmd,
  output logic       timeout
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int WD_W         = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         sync_r;
  logic               rx_s;
  logic               rx_prev_r;
  logic [CNT_W-1:0]   clk_cnt_r, clk_cnt_s;
  logic [2:0]         bit_cnt_r, bit_cnt_s;
  logic [7:0]         shift_r, shift_s;
  logic               byte_ok_s;
  logic               frame_err_s;
  logic [WD_W-1:0]    wd_cnt_r;

  // Command decode: 0x00 stops both, low half drives motor 1, high half drives motor 2.
  function automatic logic [15:0] decode_cmd(input logic [7:0] b,
                                             input logic [7:0] m1,
                                             input logic [7:0] m2);
    logic [15:0] res;
    if (b == 8'h00) begin
      res = {8'h00, 8'h00};
    end else if (b[7] == 1'b0) begin
      res = {b - 8'd64, m2};
    end else begin
      res = {m1, b - 8'd192};
    end
    return res;
  endfunction

  assign rx_s = sync_r[1];

  // Input synchroniser and edge-detect history; idles high so reset looks like a quiet line.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_r    <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[0], uart_in};
      rx_prev_r <= rx_s;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      clk_cnt_r <= '0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
    end
  end

  // Next-state logic: start validated at half a bit, data and stop sampled mid-bit.
  always_comb begin
    state_s     = state_r;
    clk_cnt_s   = clk_cnt_r + CNT_W'(1);
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    byte_ok_s   = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        clk_cnt_s = '0;
        bit_cnt_s = 3'd0;
        // Only a real high-to-low transition starts a frame, so a held break never retriggers.
        if (rx_prev_r && !rx_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (clk_cnt_r == HALF_LAST) begin
          clk_cnt_s = '0;
          if (!rx_s) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (clk_cnt_r == BIT_LAST) begin
          clk_cnt_s = '0;
          shift_s   = {rx_s, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (clk_cnt_r == BIT_LAST) begin
          clk_cnt_s = '0;
          state_s   = IDLE;
          if (rx_s) begin
            byte_ok_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        clk_cnt_s = '0;
        bit_cnt_s = 3'd0;
      end
    endcase
  end

  // Registered outputs: byte/command update and watchdog; a new byte beats the timeout.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_byte       <= 8'h00;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      motor1_cmd    <= 8'h00;
      motor2_cmd    <= 8'h00;
      timeout       <= 1'b1;
      wd_cnt_r      <= '0;
    end else begin
      rx_valid      <= byte_ok_s;
      framing_error <= frame_err_s;
      if (byte_ok_s) begin
        rx_byte                  <= shift_r;
        {motor1_cmd, motor2_cmd} <= decode_cmd(shift_r, motor1_cmd, motor2_cmd);
        wd_cnt_r                 <= '0;
        timeout                  <= 1'b0;
      end else if (wd_cnt_r != WD_MAX) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
        if ((wd_cnt_r + WD_W'(1)) == WD_MAX) begin
          timeout    <= 1'b1;
          motor1_cmd <= 8'h00;
          motor2_cmd <= 8'h00;
        end else begin
          timeout <= timeout;
        end
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_motor_uart_rx.sv
// Scoreboard bench for motor_uart_rx: directed and random 8N1 frames, with a
// per-cycle reference model of the byte/command/watchdog outputs.
module tb_motor_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int TO       = 4000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_in;
  logic [7:0] rx_byte, motor1_cmd, motor2_cmd;
  logic       rx_valid, framing_error, timeout;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, owned by the monitor
  logic [7:0] m1_m, m2_m, byte_m;
  bit         seen_m;
  int         since_m;
  exp_t       e;
  bit         valid_evt;

  always #5 clk = ~clk;

  motor_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .reset(reset), .uart_in(uart_in), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .framing_error(framing_error), .motor1_cmd(motor1_cmd),
    .motor2_cmd(motor2_cmd), .timeout(timeout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each pulse and tracks the spec-level model.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_state", {rx_byte, rx_valid, framing_error, motor1_cmd, motor2_cmd, timeout},
            {8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1});
      m1_m = 8'h00; m2_m = 8'h00; byte_m = 8'h00; seen_m = 1'b0; since_m = 0;
    end else begin
      valid_evt = 1'b0;
      if (rx_valid || framing_error) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b expected none at %0t",
                   rx_valid, framing_error, $time);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", {rx_valid, framing_error}, e.is_err ? 2'b01 : 2'b10);
          if (!e.is_err) begin
            valid_evt = 1'b1;
            byte_m    = e.data;
            if (e.data == 8'h00) begin
              m1_m = 8'h00; m2_m = 8'h00;
            end else if (int'(e.data) < 128) begin
              m1_m = 8'(int'(e.data) - 64);
            end else begin
              m2_m = 8'(int'(e.data) - 192);
            end
            seen_m  = 1'b1;
            since_m = 0;
          end
        end
      end
      if (!valid_evt && seen_m) since_m++;
      if (seen_m && since_m >= TO) begin
        m1_m = 8'h00; m2_m = 8'h00;
      end
      check("outputs", {rx_byte, motor1_cmd, motor2_cmd, timeout},
            {byte_m, m1_m, m2_m, (!seen_m || since_m >= TO)});
    end
  end

  task automatic drive_bit(input logic v, input int n);
    uart_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_pulse);
    if (expect_pulse) sb_q.push_back({~stop, b});
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1);
    drive_bit(1'b1, 3);
  endtask

  initial begin
    reset   = 1'b1;
    uart_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    drive_bit(1'b1, 10);

    // Command ranges and the stop code
    good(8'h7F); good(8'h40);
    good(8'h80); good(8'hFF); good(8'hC0);
    good(8'h01); good(8'h00);

    // Framing error followed by a held break, then recovery
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b0, 20 * CPB);
    drive_bit(1'b1, 5);
    good(8'h7F);

    // Short low glitch on an idle line must not produce a frame
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3 * CPB);
    good(8'h22);

    // Back-to-back frames with no idle gap
    send_frame(8'h91, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    drive_bit(1'b1, 4);

    // Random frames, some with a bad stop bit
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop, 1'b1);
      drive_bit(1'b1, $urandom_range(2, 30));
    end

    // Watchdog expiry after silence
    good(8'h7F);
    drive_bit(1'b1, TO + 50);
    good(8'hA5);

    // Reset mid-frame: no pulse, fresh edge required afterwards
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 3 * CPB);
    @(posedge clk);
    #1 reset = 1'b1;
    uart_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    drive_bit(1'b1, 2 * CPB);
    good(8'h7F);

    drive_bit(1'b1, 3 * CPB);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_uart_rx.md
# motor_uart_rx

Serial receiver and command decoder for the packetised-serial byte stream that `drive_motor` transmits on GPIO[5]. It sits at the motor-controller end of that link, on a second board or in the system bench as a behavioural stand-in for the motor controller. It deframes 8N1 UART bytes and decodes them into two signed motor commands. A watchdog forces both motors to stop when the stream goes silent.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 9600: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (5208 at defaults). HALF_BIT = CLKS_PER_BIT/2 (2604).
- TIMEOUT_CYCLES, 25_000_000: idle cycles without a valid byte before forced stop.

Ports:
- CLOCK_50, input, 1: the single clock.
- reset, input, 1: asynchronous, active-high reset.
- uart_in, input, 1: serial line, idle high, asynchronous to CLOCK_50.
- rx_byte, output, 8: last correctly framed byte.
- rx_valid, output, 1: one-cycle pulse when rx_byte updates.
- framing_error, output, 1: one-cycle pulse when the stop bit is sampled low.
- motor1_cmd, output, 8: signed motor-1 command, range -63..+63.
- motor2_cmd, output, 8: signed motor-2 command, range -64..+63.
- timeout, output, 1: high while no valid byte has arrived within TIMEOUT_CYCLES.

## Operation
- uart_in passes through a 2-flop synchroniser. This gives rx_s. A registered copy rx_prev is used for edge detection.
- States:
  - IDLE: bit counter and clock counter are cleared. Leave for START only on a falling edge, i.e. rx_prev=1 and rx_s=0. A line held low (break) never retriggers.
  - START: count cycles. At count HALF_BIT-1, sample rx_s. If rx_s=0, clear the counter and go to DATA. If rx_s=1, the start was false; go to IDLE with no pulses.
  - DATA: at count CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first. Clear the counter. After 8 bits go to STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s. If it is 1, register the byte into rx_byte, pulse rx_valid and run the decode. If it is 0, pulse framing_error and leave rx_byte and the commands unchanged. Go to IDLE in both cases.
- Decode, applied on rx_valid only:
  - Byte 0x00: both commands become 0.
  - Byte b in 0x01..0x7F: motor1_cmd = b - 64. motor2_cmd is unchanged.
  - Byte b in 0x80..0xFF: motor2_cmd = b - 192, computed as 8-bit two's complement. motor1_cmd is unchanged.
- Watchdog:
  - A counter clears on every rx_valid and otherwise increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: timeout=1 and both commands are forced to 0.
  - The next rx_valid clears timeout in the same cycle and applies its decode.
- Framing errors do not reset the watchdog.

## Timing
- Reset values:
  - State IDLE.
  - rx_byte=0x00, rx_valid=0, framing_error=0.
  - motor1_cmd=0, motor2_cmd=0.
  - timeout=1, because no command has been received yet.
  - Watchdog counter=0.
  - Synchroniser flops=1.
- Latency:
  - uart_in to rx_s: 2 cycles.
  - Start edge to the start-bit sample: HALF_BIT cycles.
  - Each data and stop sample lands mid-bit.
  - rx_valid, framing_error and the command updates are registered together, one cycle after the stop sample.
- Pulse width: rx_valid and framing_error are each high for exactly 1 cycle. They are never high in the same cycle.
- Timeout and rx_valid in the same cycle: rx_valid wins. The commands take the decoded value and timeout=0.
- Reset asserted mid-frame: everything returns to reset values immediately and no pulse is emitted. After release, reception resumes only on a fresh falling edge.
- Back-to-back frames: a start edge arriving one cycle after STOP exits is accepted.

## Test plan
All scenarios use the default parameters unless stated.
- Frame 0x7F, then frame 0x40 -> rx_valid pulses twice. motor1_cmd = +63, then 0. motor2_cmd stays 0. timeout drops to 0 on the first pulse.
- Frame 0x80, then 0xFF, then 0xC0 -> motor2_cmd = -64 (0xC0), then +63 (0x3F), then 0. motor1_cmd is unchanged.
- Frame 0x01 then 0x00 -> motor1_cmd = -63 (0xC1), then both commands = 0.
- Frame 0x55 with the stop bit driven low, then the line held low for 20 bit times -> exactly one framing_error pulse, no rx_valid, rx_byte unchanged, no further frames detected. After the line returns high, frame 0x7F -> motor1_cmd = +63.
- 1000-cycle low glitch on an idle line -> no rx_valid or framing_error. State back in IDLE by cycle HALF_BIT+3.
- With TIMEOUT_CYCLES=100_000: frame 0x7F, then silence -> timeout=1 and motor1_cmd=0 exactly 100_000 cycles after the rx_valid pulse. Reset asserted in the middle of the next frame -> no pulse, all outputs at reset values.
